// File: rtl/sci_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sci_bus_arbiter
// Brief    : Two-master arbiter/sequencer for the SCI register bus. Each granted
//            request becomes a setup / strobe / hold bus cycle followed by an ack.
//            Define SCI_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties);
//            round-robin otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module sci_bus_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] sciaddr,
    output logic [DATA_W-1:0] sciwdata,
    output logic              sciwstn,
    output logic              scird,
    input  logic [DATA_W-1:0] scirmxdata,
    output logic              busy
);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup_cyc
            $error("sci_bus_arbiter: SETUP_CYC must be within 1..15");
        end
        if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe_cyc
            $error("sci_bus_arbiter: STROBE_CYC must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] c_setup_load  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_strobe_load = 4'(STROBE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t              r_state_q,    w_state_d;
    logic [3:0]          r_cnt_q,      w_cnt_d;
    logic                r_winner_q,   w_winner_d;
    logic                r_we_q,       w_we_d;
    logic [ADDR_W-1:0]   r_sciaddr_q,  w_sciaddr_d;
    logic [DATA_W-1:0]   r_sciwdata_q, w_sciwdata_d;
    logic                r_sciwstn_q,  w_sciwstn_d;
    logic                r_scird_q,    w_scird_d;
    logic                r_m0_ack_q,   w_m0_ack_d;
    logic                r_m1_ack_q,   w_m1_ack_d;
    logic [DATA_W-1:0]   r_m0_rdata_q, w_m0_rdata_d;
    logic [DATA_W-1:0]   r_m1_rdata_q, w_m1_rdata_d;
    logic                r_busy_q,     w_busy_d;
    logic                w_any_req;
    logic                w_grant;

`ifdef SCI_ARB_FIXED_PRIO_EN
    assign w_grant = ~m0_req;
`else
    logic                r_rr_last_q,  w_rr_last_d;

    // Master 1 wins only when alone, or on a tie when master 0 was served last.
    assign w_grant = m1_req & (~m0_req | ~r_rr_last_q);
`endif

    assign w_any_req = m0_req | m1_req;

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_winner_d   = r_winner_q;
        w_we_d       = r_we_q;
        w_sciaddr_d  = r_sciaddr_q;
        w_sciwdata_d = r_sciwdata_q;
        w_sciwstn_d  = r_sciwstn_q;
        w_scird_d    = r_scird_q;
        w_m0_ack_d   = 1'b0;
        w_m1_ack_d   = 1'b0;
        w_m0_rdata_d = r_m0_rdata_q;
        w_m1_rdata_d = r_m1_rdata_q;
`ifndef SCI_ARB_FIXED_PRIO_EN
        w_rr_last_d  = r_rr_last_q;
`endif

        unique case (r_state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_winner_d   = w_grant;
                    w_we_d       = w_grant ? m1_we    : m0_we;
                    w_sciaddr_d  = w_grant ? m1_addr  : m0_addr;
                    w_sciwdata_d = w_grant ? m1_wdata : m0_wdata;
                    w_cnt_d      = c_setup_load;
                    w_state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (r_cnt_q == 4'd0) begin
                    w_cnt_d     = c_strobe_load;
                    w_scird_d   = ~r_we_q;
                    w_sciwstn_d = ~r_we_q;
                    w_state_d   = ST_STROBE;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (r_cnt_q == 4'd0) begin
                    w_cnt_d     = 4'd0;
                    w_scird_d   = 1'b0;
                    w_sciwstn_d = 1'b1;
                    w_state_d   = ST_HOLD;
                    // Read data is sampled at the close of the final strobe cycle.
                    if (!r_we_q) begin
                        if (r_winner_q) begin
                            w_m1_rdata_d = scirmxdata;
                        end else begin
                            w_m0_rdata_d = scirmxdata;
                        end
                    end
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                w_cnt_d    = 4'd0;
                w_m0_ack_d = ~r_winner_q;
                w_m1_ack_d = r_winner_q;
`ifndef SCI_ARB_FIXED_PRIO_EN
                w_rr_last_d = r_winner_q;
`endif
                w_state_d  = ST_DONE;
            end
            ST_DONE: begin
                w_cnt_d   = 4'd0;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_cnt_q      <= 4'd0;
            r_winner_q   <= 1'b0;
            r_we_q       <= 1'b0;
            r_sciaddr_q  <= '0;
            r_sciwdata_q <= '0;
            r_sciwstn_q  <= 1'b1;
            r_scird_q    <= 1'b0;
            r_m0_ack_q   <= 1'b0;
            r_m1_ack_q   <= 1'b0;
            r_m0_rdata_q <= '0;
            r_m1_rdata_q <= '0;
            r_busy_q     <= 1'b0;
`ifndef SCI_ARB_FIXED_PRIO_EN
            r_rr_last_q  <= 1'b1;
`endif
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_winner_q   <= w_winner_d;
            r_we_q       <= w_we_d;
            r_sciaddr_q  <= w_sciaddr_d;
            r_sciwdata_q <= w_sciwdata_d;
            r_sciwstn_q  <= w_sciwstn_d;
            r_scird_q    <= w_scird_d;
            r_m0_ack_q   <= w_m0_ack_d;
            r_m1_ack_q   <= w_m1_ack_d;
            r_m0_rdata_q <= w_m0_rdata_d;
            r_m1_rdata_q <= w_m1_rdata_d;
            r_busy_q     <= w_busy_d;
`ifndef SCI_ARB_FIXED_PRIO_EN
            r_rr_last_q  <= w_rr_last_d;
`endif
        end
    end

    assign sciaddr  = r_sciaddr_q;
    assign sciwdata = r_sciwdata_q;
    assign sciwstn  = r_sciwstn_q;
    assign scird    = r_scird_q;
    assign m0_ack   = r_m0_ack_q;
    assign m1_ack   = r_m1_ack_q;
    assign m0_rdata = r_m0_rdata_q;
    assign m1_rdata = r_m1_rdata_q;
    assign busy     = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sci_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sci_bus_arbiter
// Brief    : Self-checking bench for sci_bus_arbiter (default and 3/1 timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sci_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [17:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [7:0]  m0_rdata, m1_rdata;
    logic [17:0] sciaddr;
    logic [7:0]  sciwdata;
    logic        sciwstn, scird, busy;
    logic [7:0]  scirmxdata;

    logic        p_m0_req, p_m0_we, p_m1_req, p_m1_we;
    logic [17:0] p_m0_addr, p_m1_addr;
    logic [7:0]  p_m0_wdata, p_m1_wdata;
    logic        p_m0_ack, p_m1_ack;
    logic [7:0]  p_m0_rdata, p_m1_rdata;
    logic [17:0] p_sciaddr;
    logic [7:0]  p_sciwdata;
    logic        p_sciwstn, p_scird, p_busy;
    logic [7:0]  p_scirmxdata;

    typedef struct packed {
        logic       m;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    sci_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .sciaddr(sciaddr), .sciwdata(sciwdata), .sciwstn(sciwstn), .scird(scird),
        .scirmxdata(scirmxdata), .busy(busy)
    );

    sci_bus_arbiter #(.SETUP_CYC(3), .STROBE_CYC(1)) dut_p (
        .clk(clk), .rst(rst),
        .m0_req(p_m0_req), .m0_we(p_m0_we), .m0_addr(p_m0_addr), .m0_wdata(p_m0_wdata),
        .m0_ack(p_m0_ack), .m0_rdata(p_m0_rdata),
        .m1_req(p_m1_req), .m1_we(p_m1_we), .m1_addr(p_m1_addr), .m1_wdata(p_m1_wdata),
        .m1_ack(p_m1_ack), .m1_rdata(p_m1_rdata),
        .sciaddr(p_sciaddr), .sciwdata(p_sciwdata), .sciwstn(p_sciwstn), .scird(p_scird),
        .scirmxdata(p_scirmxdata), .busy(p_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checkw(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    task automatic drive(input bit m, input bit req, input bit we,
                         input logic [17:0] a, input logic [7:0] d);
        if (m) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    // One isolated transaction on the default-timing instance; the master drops
    // req and scrambles its command right after the grant.
    task automatic txn_default(input bit m, input bit we, input logic [17:0] a,
                               input logic [7:0] d);
        logic strobe;
        sb.push_back('{m: m, rd: !we, data: scirmxdata});
        drive(m, 1'b1, we, a, d);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) drive(m, 1'b0, !we, ~a, ~d);
            strobe = (c == 2 || c == 3);
            check1("busy", busy, c <= 5);
            check1("scird", scird, !we && strobe);
            check1("sciwstn", sciwstn, !(we && strobe));
            if (c <= 5) begin
                checkw("sciaddr", 32'(sciaddr), 32'(a));
                checkw("sciwdata", 32'(sciwdata), 32'(d));
            end
            checkw("ack", {30'd0, m1_ack, m0_ack},
                   (c == 5) ? (m ? 32'd2 : 32'd1) : 32'd0);
        end
    endtask

    // Scoreboard: every ack from the default instance must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (m0_ack || m1_ack)) begin
            if (sb.size() == 0) begin
                checkw("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkw("ack_owner", {30'd0, m1_ack, m0_ack}, mon_e.m ? 32'd2 : 32'd1);
                if (mon_e.rd)
                    checkw("rdata", 32'(mon_e.m ? m1_rdata : m0_rdata), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acks;
        bit  prev_ack;
        bit  found;

        rst = 1'b1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        scirmxdata = 8'h00;
        p_m0_req = 0; p_m0_we = 0; p_m0_addr = '0; p_m0_wdata = '0;
        p_m1_req = 0; p_m1_we = 0; p_m1_addr = '0; p_m1_wdata = '0;
        p_scirmxdata = 8'h00;
        repeat (3) @(negedge clk);

        check1("rst_sciwstn", sciwstn, 1'b1);
        check1("rst_scird", scird, 1'b0);
        checkw("rst_sciaddr", 32'(sciaddr), 32'd0);
        checkw("rst_sciwdata", 32'(sciwdata), 32'd0);
        checkw("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        checkw("rst_rdata", {16'd0, m1_rdata, m0_rdata}, 32'd0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_p_busy", p_busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single read from master 0, then single write from master 1.
        scirmxdata = 8'hA5;
        txn_default(0, 0, 18'h00123, 8'h00);
        txn_default(1, 1, 18'h3FFFF, 8'h5A);

        // Both masters hold req: m0 reads, m1 writes.
`ifdef SCI_ARB_FIXED_PRIO_EN
        sb.push_back('{m: 0, rd: 1, data: 8'hA5});
        sb.push_back('{m: 0, rd: 1, data: 8'hA5});
        sb.push_back('{m: 0, rd: 1, data: 8'hA5});
        sb.push_back('{m: 0, rd: 1, data: 8'hA5});
`else
        sb.push_back('{m: 0, rd: 1, data: 8'hA5});
        sb.push_back('{m: 1, rd: 0, data: 8'h00});
        sb.push_back('{m: 0, rd: 1, data: 8'hA5});
        sb.push_back('{m: 1, rd: 0, data: 8'h00});
`endif
        sb.push_back('{m: 1, rd: 0, data: 8'h00});
        drive(0, 1, 0, 18'h00010, 8'h00);
        drive(1, 1, 1, 18'h00020, 8'h77);
        acks = 0;
        prev_ack = 0;
        for (int i = 0; i < 80 && acks < 5; i++) begin
            @(negedge clk);
            if (prev_ack) check1("idle_gap", busy, 1'b0);
            prev_ack = m0_ack | m1_ack;
            if (prev_ack) begin
                acks++;
                if (acks == 4) m0_req = 1'b0;
                if (acks == 5) m1_req = 1'b0;
            end
        end
        checkw("tie_ack_count", 32'(acks), 32'd5);
        @(negedge clk);
        check1("tie_end_idle", busy, 1'b0);

        // Reset lands while a write strobe is active.
        drive(1, 1, 1, 18'h2AAAA, 8'hC3);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (sciwstn === 1'b0) found = 1;
        end
        check1("rst_reach_strobe", found, 1'b1);
        rst = 1'b1;
        m1_req = 1'b0;
        @(negedge clk);
        check1("mid_rst_sciwstn", sciwstn, 1'b1);
        check1("mid_rst_busy", busy, 1'b0);
        checkw("mid_rst_sciaddr", 32'(sciaddr), 32'd0);
        checkw("mid_rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("post_rst_idle", busy, 1'b0);
        end

        // Instance with 3 setup cycles and a 1-cycle strobe.
        p_scirmxdata = 8'h3C;
        p_m0_addr = 18'h0ABCD;
        p_m0_we = 1'b0;
        p_m0_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) p_m0_req = 1'b0;
            check1("p_scird", p_scird, c == 4);
            check1("p_sciwstn", p_sciwstn, 1'b1);
            check1("p_busy", p_busy, c <= 6);
            check1("p_m0_ack", p_m0_ack, c == 6);
            check1("p_m1_ack", p_m1_ack, 1'b0);
            if (c <= 6) begin
                checkw("p_sciaddr", 32'(p_sciaddr), 32'h0ABCD);
                checkw("p_sciwdata", 32'(p_sciwdata), 32'd0);
            end
            if (c == 6) checkw("p_m0_rdata", 32'(p_m0_rdata), 32'h3C);
        end
        checkw("p_m1_rdata", 32'(p_m1_rdata), 32'd0);

        checkw("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
